// File: rtl/digit_stream_writer_pkg.sv
// Shared definitions for the digit stream writer: FSM state encoding and
// the ASCII constants used for blanking and reset values.
package digit_stream_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_SEND   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

endpackage

// File: rtl/digit_stream_writer.sv
// Digit stream writer: on start, walks col from SIZE_DECIMAL-1 down to 0,
// fetches each ASCII digit from the external converter and offers it to a
// valid/ready sink, then pulses done.
// Optional feature: define LEADING_BLANK_EN to replace leading '0' digits
// (all columns except column 0) with spaces.
module digit_stream_writer
    import digit_stream_writer_pkg::*;
#(
    parameter int SIZE_DECIMAL = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic [SIZE_DECIMAL-1:0] col,
    input  logic [7:0]              char_in,
    output logic [7:0]              char_out,
    output logic                    char_valid,
    input  logic                    char_ready,
    output logic                    busy,
    output logic                    done
);

    localparam logic [SIZE_DECIMAL-1:0] COL_TOP = SIZE_DECIMAL'(SIZE_DECIMAL - 1);

    state_t                  state_reg, state_next;
    logic [SIZE_DECIMAL-1:0] col_reg, col_next;
    logic [7:0]              char_out_reg, char_out_next;
    logic                    valid_reg, valid_next;
    logic                    busy_reg, busy_next;
    logic                    done_reg, done_next;
    logic [7:0]              fetch_char;

`ifdef LEADING_BLANK_EN
    // Set once a nonzero digit has been fetched in the current frame.
    logic                    seen_reg, seen_next;

    // Blank a '0' until the first nonzero digit; the units column is never blanked.
    always_comb begin
        fetch_char = char_in;
        if (!seen_reg && (char_in == ASCII_ZERO) && (col_reg != '0)) begin
            fetch_char = ASCII_SPACE;
        end
    end

    // Leading-zero tracking flag register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seen_reg <= 1'b0;
        end else begin
            seen_reg <= seen_next;
        end
    end
`else
    // Converter output passes through untouched.
    always_comb begin
        fetch_char = char_in;
    end
`endif

    // State and datapath registers; reset abandons any frame in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            col_reg      <= '0;
            char_out_reg <= ASCII_SPACE;
            valid_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            col_reg      <= col_next;
            char_out_reg <= char_out_next;
            valid_reg    <= valid_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    // Next-state and next-output logic; done is a one-cycle pulse in FINISH.
    always_comb begin
        state_next    = state_reg;
        col_next      = col_reg;
        char_out_next = char_out_reg;
        valid_next    = valid_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
`ifdef LEADING_BLANK_EN
        seen_next     = seen_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    col_next   = COL_TOP;
                    busy_next  = 1'b1;
                    state_next = ST_FETCH;
`ifdef LEADING_BLANK_EN
                    seen_next  = 1'b0;
`endif
                end
            end
            ST_FETCH: begin
                char_out_next = fetch_char;
                valid_next    = 1'b1;
                state_next    = ST_SEND;
`ifdef LEADING_BLANK_EN
                if (char_in != ASCII_ZERO) begin
                    seen_next = 1'b1;
                end
`endif
            end
            ST_SEND: begin
                if (valid_reg && char_ready) begin
                    valid_next = 1'b0;
                    if (col_reg != '0) begin
                        col_next   = col_reg - 1'b1;
                        state_next = ST_FETCH;
                    end else begin
                        done_next  = 1'b1;
                        state_next = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                busy_next  = 1'b0;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign col        = col_reg;
    assign char_out   = char_out_reg;
    assign char_valid = valid_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_digit_stream_writer.sv
// Directed testbench for digit_stream_writer with SIZE_DECIMAL=4. A small
// converter model feeds char_in from a static value; the driver task acts as
// start source, sink and reset source, and each test task checks its results.
module tb_digit_stream_writer;

    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [SD-1:0] col;
    logic [7:0]    char_in;
    logic [7:0]    char_out;
    logic          char_valid;
    logic          char_ready = 1'b1;
    logic          busy;
    logic          done;

    int            value = 0;
    int            total = 0;
    int            bad = 0;

    logic [7:0]    got [0:15];
    int            nhs;
    int            ndone;
    int            done_cyc;

    digit_stream_writer #(.SIZE_DECIMAL(SD)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .col        (col),
        .char_in    (char_in),
        .char_out   (char_out),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ascii_digit(input int v, input int c);
        int d;
        d = v;
        for (int i = 0; i < c; i++) d = d / 10;
        return 8'(48 + (d % 10));
    endfunction

    assign char_in = ascii_digit(value, int'(col));

    // Runs one frame over a fixed 30-cycle window, recording accepted chars.
    task automatic drive_frame(input int val, input int stall_col, input int stall_n,
                               input int start_col, input int rst_col);
        int stalled;
        bit did_start;
        bit did_rst;
        bit rst_now;
        value     = val;
        nhs       = 0;
        ndone     = 0;
        done_cyc  = -1;
        stalled   = 0;
        did_start = 1'b0;
        did_rst   = 1'b0;
        @(negedge clk);
        char_ready = 1'b1;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 30; k++) begin
            rst_now = 1'b0;
            reset   = 1'b0;
            start   = 1'b0;
            if (rst_col >= 0 && !did_rst && char_valid && int'(col) == rst_col) begin
                did_rst = 1'b1;
                rst_now = 1'b1;
                reset   = 1'b1;
                #1;
                total++;
                if (char_valid !== 1'b0 || busy !== 1'b0 || char_out !== 8'h20) begin
                    bad++;
                    $display("FAIL rst_mid: valid=%b busy=%b char=%h required 0 0 20",
                             char_valid, busy, char_out);
                end
            end
            if (start_col >= 0 && !did_start && busy && int'(col) == start_col) begin
                did_start = 1'b1;
                start     = 1'b1;
            end
            if (stall_col >= 0 && char_valid && int'(col) == stall_col && stalled < stall_n) begin
                stalled++;
                char_ready = 1'b0;
                total++;
                if (char_out !== 8'h30 || char_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL stall_hold: char=%h valid=%b required 30 1",
                             char_out, char_valid);
                end
            end else begin
                char_ready = 1'b1;
            end
            if (done === 1'b1) begin
                ndone++;
                done_cyc = k;
            end
            if (!rst_now && char_valid && char_ready && nhs < 16) begin
                got[nhs] = char_out;
                nhs++;
            end
            @(negedge clk);
        end
        reset      = 1'b0;
        start      = 1'b0;
        char_ready = 1'b1;
    endtask

    // Compares the captured four characters and frame counts.
    task automatic check_frame(input string name, input logic [31:0] exp,
                               input int exp_hs, input int exp_done, input int exp_cyc);
        logic [7:0] e;
        total++;
        if (nhs !== exp_hs) begin
            bad++;
            $display("FAIL %s_handshakes: got %0d required %0d", name, nhs, exp_hs);
        end
        for (int i = 0; i < exp_hs && i < 4; i++) begin
            e = exp[31 - 8*i -: 8];
            total++;
            if (got[i] !== e) begin
                bad++;
                $display("FAIL %s_char%0d: got %h required %h", name, i, got[i], e);
            end
        end
        total++;
        if (ndone !== exp_done) begin
            bad++;
            $display("FAIL %s_done_count: got %0d required %0d", name, ndone, exp_done);
        end
        if (exp_cyc >= 0) begin
            total++;
            if (done_cyc !== exp_cyc) begin
                bad++;
                $display("FAIL %s_done_cycle: got %0d required %0d", name, done_cyc, exp_cyc);
            end
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_busy_after: got %b required 0", name, busy);
        end
        $display("frame %s: val=%0d handshakes=%0d done=%0d at cycle %0d",
                 name, value, nhs, ndone, done_cyc);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total += 5;
        if (col !== 4'd0)       begin bad++; $display("FAIL reset_col: got %h required 0", col); end
        if (char_out !== 8'h20) begin bad++; $display("FAIL reset_char: got %h required 20", char_out); end
        if (char_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b required 0", char_valid); end
        if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
        if (done !== 1'b0)      begin bad++; $display("FAIL reset_done: got %b required 0", done); end
        reset = 1'b0;
        @(negedge clk);
        $display("reset: col=%h char=%h valid=%b busy=%b done=%b",
                 col, char_out, char_valid, busy, done);
    endtask

    task automatic test_basic();
        drive_frame(37, -1, 0, -1, -1);
`ifdef LEADING_BLANK_EN
        check_frame("v37", {8'h20, 8'h20, 8'h33, 8'h37}, 4, 1, 9);
`else
        check_frame("v37", {8'h30, 8'h30, 8'h33, 8'h37}, 4, 1, 9);
`endif
    endtask

    task automatic test_zero();
        drive_frame(0, -1, 0, -1, -1);
`ifdef LEADING_BLANK_EN
        check_frame("v0", {8'h20, 8'h20, 8'h20, 8'h30}, 4, 1, 9);
`else
        check_frame("v0", {8'h30, 8'h30, 8'h30, 8'h30}, 4, 1, 9);
`endif
        drive_frame(9999, -1, 0, -1, -1);
        check_frame("v9999", {8'h39, 8'h39, 8'h39, 8'h39}, 4, 1, 9);
    endtask

    task automatic test_stall();
        drive_frame(1005, 2, 3, -1, -1);
        check_frame("stall", {8'h31, 8'h30, 8'h30, 8'h35}, 4, 1, 12);
    endtask

    task automatic test_back_to_back();
        drive_frame(37, -1, 0, 1, -1);
`ifdef LEADING_BLANK_EN
        check_frame("busy_start", {8'h20, 8'h20, 8'h33, 8'h37}, 4, 1, 9);
`else
        check_frame("busy_start", {8'h30, 8'h30, 8'h33, 8'h37}, 4, 1, 9);
`endif
    endtask

    task automatic test_reset_mid();
        drive_frame(1234, -1, 0, -1, 2);
        total++;
        if (nhs !== 1 || got[0] !== 8'h31) begin
            bad++;
            $display("FAIL rst_mid_partial: handshakes=%0d first=%h required 1 31", nhs, got[0]);
        end
        total++;
        if (ndone !== 0) begin
            bad++;
            $display("FAIL rst_mid_no_done: got %0d required 0", ndone);
        end
        $display("frame rst_mid: val=1234 handshakes=%0d done=%0d", nhs, ndone);
        drive_frame(1234, -1, 0, -1, -1);
        check_frame("after_rst", {8'h31, 8'h32, 8'h33, 8'h34}, 4, 1, 9);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
